// File: rtl/raster_n.sv
// raster_n: scanline triangle rasteriser driven by VGA-style x/y counters.
// Every VGA pixel takes two clock cycles (phases):
//   EVAL  (phase 0) - step the barycentrics, classify each triangle against
//                     the current edge values, choose the winning triangle,
//                     and register its index, facing and texture address.
//   SHADE (phase 1) - the texel for that address is now valid. Resolve the
//                     pixel colour, count foreground coverage and step the
//                     edge functions to the next pixel.
// The edge and barycentric accumulators reload from their line-start values
// at the end of each visible line and at the end of the frame.
//
// Timing: a pixel's colour appears on rgb two clock edges after its EVAL
// cycle begins (EVAL edge plus SHADE edge). Outside the visible area rgb
// reads 0.
module raster_n #(
    parameter int NTRI = 2,
    parameter int EW   = 20,
    parameter int BW   = 22,
    parameter int UVW  = 7,
    localparam int TIW = (NTRI > 1) ? $clog2(NTRI) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic [2:0]           mode,
    input  logic [NTRI-1:0]      tri_en,
    input  logic [NTRI*3*EW-1:0] e_init,
    input  logic [NTRI*3*EW-1:0] e_dx,
    input  logic [NTRI*BW-1:0]   by_init,
    input  logic [NTRI*BW-1:0]   by_dx,
    input  logic [NTRI*BW-1:0]   bz_init,
    input  logic [NTRI*BW-1:0]   bz_dx,
    input  logic [NTRI*6-1:0]    tri_color,
    input  logic [5:0]           bg_color,
    output logic [UVW-1:0]       tex_u,
    output logic [UVW-1:0]       tex_v,
    input  logic                 tex_texel,
    output logic [5:0]           rgb,
    output logic [TIW-1:0]       hit_idx,
    output logic [18:0]          cov_count,
    output logic                 cov_valid
);

    localparam logic [9:0] X_ACTIVE  = 10'd640;
    localparam logic [9:0] Y_ACTIVE  = 10'd480;
    localparam logic [9:0] X_LAST    = 10'd799;
    localparam logic [9:0] Y_LAST    = 10'd524;
    localparam logic [5:0] COL_FRONT = 6'b111111;
    localparam logic [5:0] COL_BACK  = 6'b101010;
    localparam logic [5:0] COL_BLACK = 6'b000000;

    typedef enum logic {
        PH_EVAL  = 1'b0,
        PH_SHADE = 1'b1
    } phase_e;

    phase_e phase_q, phase_d;

    // Cycle qualifiers
    logic active;
    logic reload;
    logic eval_cyc;
    logic shade_cyc;
    logic snap_pos;
    logic snap;

    // Per-triangle accumulators
    logic [EW-1:0] e_q     [NTRI][3];
    logic [EW-1:0] e_d     [NTRI][3];
    logic [BW-1:0] by_q    [NTRI];
    logic [BW-1:0] by_d    [NTRI];
    logic [BW-1:0] bz_q    [NTRI];
    logic [BW-1:0] bz_d    [NTRI];
    logic [BW-1:0] by_step [NTRI];
    logic [BW-1:0] bz_step [NTRI];

    // Classification and winner search
    logic [NTRI-1:0] front;
    logic [NTRI-1:0] back;
    logic            neg_all;
    logic            pos_all;
    logic            found;
    logic [TIW-1:0]  win_idx;
    logic            win_back;
    logic [UVW-1:0]  win_u;
    logic [UVW-1:0]  win_v;

    // Shading
    logic [5:0] win_color;
    logic [5:0] shade_rgb;

    // Registered pixel state and outputs
    logic [UVW-1:0] tex_u_q, tex_u_d;
    logic [UVW-1:0] tex_v_q, tex_v_d;
    logic [TIW-1:0] hit_idx_q, hit_idx_d;
    logic           back_q, back_d;
    logic           bg_q, bg_d;
    logic [5:0]     rgb_q, rgb_d;
    logic [18:0]    acc_q, acc_d;
    logic [18:0]    cov_count_q, cov_count_d;
    logic           cov_valid_q, cov_valid_d;
    logic           snap_seen_q, snap_seen_d;

    // Decode where the beam is: visible region, reload point, snapshot point.
    // The snapshot fires only on the first cycle at (0,480), so a pixel
    // that spans two clocks still gives a single cov_valid pulse.
    always_comb begin
        active    = (x < X_ACTIVE) && (y < Y_ACTIVE);
        reload    = (x == X_LAST) && ((y < Y_ACTIVE) || (y == Y_LAST));
        eval_cyc  = active && (phase_q == PH_EVAL);
        shade_cyc = active && (phase_q == PH_SHADE);
        snap_pos  = (y == Y_ACTIVE) && (x == 10'd0);
        snap      = snap_pos && !snap_seen_q;
    end

    // Phase sequencing: toggle on every visible cycle, realign on reload.
    always_comb begin
        phase_d = phase_q;
        if (reload) begin
            phase_d = PH_EVAL;
        end else if (active) begin
            phase_d = (phase_q == PH_EVAL) ? PH_SHADE : PH_EVAL;
        end
    end

    // Phase state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PH_EVAL;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Edge functions: reload has priority, otherwise step once per SHADE.
    always_comb begin
        for (int t = 0; t < NTRI; t++) begin
            for (int k = 0; k < 3; k++) begin
                e_d[t][k] = e_q[t][k];
                if (reload) begin
                    e_d[t][k] = e_init[(3*t+k)*EW +: EW];
                end else if (shade_cyc) begin
                    e_d[t][k] = e_q[t][k] + e_dx[(3*t+k)*EW +: EW];
                end
            end
        end
    end

    // Barycentrics: reload has priority, otherwise step once per EVAL.
    // The stepped values also feed this pixel's texture address.
    always_comb begin
        for (int t = 0; t < NTRI; t++) begin
            by_step[t] = by_q[t] + by_dx[t*BW +: BW];
            bz_step[t] = bz_q[t] + bz_dx[t*BW +: BW];
            by_d[t]    = by_q[t];
            bz_d[t]    = bz_q[t];
            if (reload) begin
                by_d[t] = by_init[t*BW +: BW];
                bz_d[t] = bz_init[t*BW +: BW];
            end else if (eval_cyc) begin
                by_d[t] = by_step[t];
                bz_d[t] = bz_step[t];
            end
        end
    end

    // Classify each triangle as front (all edges < 0) or back (all edges > 0).
    // A zero on any edge counts as a miss, so it is neither front nor back.
    always_comb begin
        front   = '0;
        back    = '0;
        neg_all = 1'b0;
        pos_all = 1'b0;
        for (int t = 0; t < NTRI; t++) begin
            neg_all = 1'b1;
            pos_all = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (!e_q[t][k][EW-1]) begin
                    neg_all = 1'b0;
                end
                if (e_q[t][k][EW-1] || (e_q[t][k] == '0)) begin
                    pos_all = 1'b0;
                end
            end
            front[t] = neg_all;
            back[t]  = pos_all;
        end
    end

    // Priority search: the lowest enabled index with a qualifying hit wins.
    // When culling is on, a back-facing hit is skipped and the search goes on.
    // u is the stepped bz; v is the stepped by plus bz. Both take the UVW
    // bits just below the two integer bits of the Q2 value.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        win_back = 1'b0;
        win_u    = '0;
        win_v    = '0;
        for (int t = 0; t < NTRI; t++) begin
            if (!found && tri_en[t] && (front[t] || (back[t] && !mode[2]))) begin
                found    = 1'b1;
                win_idx  = TIW'(t);
                win_back = back[t];
                win_u    = bz_step[t][BW-3 -: UVW];
                win_v    = UVW'((by_step[t] + bz_step[t]) >> (BW - 2 - UVW));
            end
        end
    end

    // Resolve the SHADE colour from the EVAL results and the returned texel.
    always_comb begin
        win_color = '0;
        for (int t = 0; t < NTRI; t++) begin
            if (hit_idx_q == TIW'(t)) begin
                win_color = tri_color[t*6 +: 6];
            end
        end
        shade_rgb = bg_color;
        if (!bg_q) begin
            case (mode[1:0])
                2'd0:    shade_rgb = tex_texel ? win_color : bg_color;
                2'd1:    shade_rgb = back_q ? COL_BACK : COL_FRONT;
                2'd2:    shade_rgb = win_color;
                default: shade_rgb = COL_BLACK;
            endcase
        end
    end

    // Next-state logic for the pixel pipeline, rgb and coverage counter.
    always_comb begin
        tex_u_d     = tex_u_q;
        tex_v_d     = tex_v_q;
        hit_idx_d   = hit_idx_q;
        back_d      = back_q;
        bg_d        = bg_q;
        rgb_d       = rgb_q;
        acc_d       = acc_q;
        cov_count_d = cov_count_q;
        cov_valid_d = 1'b0;
        snap_seen_d = snap_pos;

        if (eval_cyc) begin
            hit_idx_d = win_idx;
            back_d    = win_back;
            bg_d      = !found;
            tex_u_d   = win_u;
            tex_v_d   = win_v;
        end

        if (!active) begin
            rgb_d = '0;
        end else if (shade_cyc) begin
            rgb_d = shade_rgb;
        end

        if (snap) begin
            cov_count_d = acc_q;
            cov_valid_d = 1'b1;
            acc_d       = '0;
        end else if (shade_cyc && !bg_q) begin
            acc_d = acc_q + 19'd1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NTRI; t++) begin
                for (int k = 0; k < 3; k++) begin
                    e_q[t][k] <= '0;
                end
                by_q[t] <= '0;
                bz_q[t] <= '0;
            end
            tex_u_q     <= '0;
            tex_v_q     <= '0;
            hit_idx_q   <= '0;
            back_q      <= 1'b0;
            bg_q        <= 1'b0;
            rgb_q       <= '0;
            acc_q       <= '0;
            cov_count_q <= '0;
            cov_valid_q <= 1'b0;
            snap_seen_q <= 1'b0;
        end else begin
            e_q         <= e_d;
            by_q        <= by_d;
            bz_q        <= bz_d;
            tex_u_q     <= tex_u_d;
            tex_v_q     <= tex_v_d;
            hit_idx_q   <= hit_idx_d;
            back_q      <= back_d;
            bg_q        <= bg_d;
            rgb_q       <= rgb_d;
            acc_q       <= acc_d;
            cov_count_q <= cov_count_d;
            cov_valid_q <= cov_valid_d;
            snap_seen_q <= snap_seen_d;
        end
    end

    assign tex_u     = tex_u_q;
    assign tex_v     = tex_v_q;
    assign rgb       = rgb_q;
    assign hit_idx   = hit_idx_q;
    assign cov_count = cov_count_q;
    assign cov_valid = cov_valid_q;

endmodule

// File: tb/tb_raster_n.sv
// tb_raster_n: directed bench for raster_n. The bench drives the VGA
// counters, holding each pixel for two clocks (EVAL, then SHADE), and
// compares outputs against hand-computed values one clock cycle at a time,
// #1 after each rising edge.
module tb_raster_n;

    localparam int NTRI = 2;
    localparam int EW   = 20;
    localparam int BW   = 22;
    localparam int UVW  = 7;
    localparam int TIW  = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [9:0]           x;
    logic [9:0]           y;
    logic [2:0]           mode;
    logic [NTRI-1:0]      tri_en;
    logic [NTRI*3*EW-1:0] e_init;
    logic [NTRI*3*EW-1:0] e_dx;
    logic [NTRI*BW-1:0]   by_init;
    logic [NTRI*BW-1:0]   by_dx;
    logic [NTRI*BW-1:0]   bz_init;
    logic [NTRI*BW-1:0]   bz_dx;
    logic [NTRI*6-1:0]    tri_color;
    logic [5:0]           bg_color;
    logic [UVW-1:0]       tex_u;
    logic [UVW-1:0]       tex_v;
    logic                 tex_texel;
    logic [5:0]           rgb;
    logic [TIW-1:0]       hit_idx;
    logic [18:0]          cov_count;
    logic                 cov_valid;

    logic                 tex_tie;
    logic                 tex_fix;
    logic [5:0]           exp_q[$];
    logic [5:0]           exp_rgb;

    int n_checks = 0;
    int n_errors = 0;

    // The texture ROM model: either a fixed texel or the low bit of tex_u.
    assign tex_texel = tex_tie ? tex_u[0] : tex_fix;

    // Clock
    always #5 clk = ~clk;

    raster_n #(
        .NTRI(NTRI),
        .EW  (EW),
        .BW  (BW),
        .UVW (UVW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .y        (y),
        .mode     (mode),
        .tri_en   (tri_en),
        .e_init   (e_init),
        .e_dx     (e_dx),
        .by_init  (by_init),
        .by_dx    (by_dx),
        .bz_init  (bz_init),
        .bz_dx    (bz_dx),
        .tri_color(tri_color),
        .bg_color (bg_color),
        .tex_u    (tex_u),
        .tex_v    (tex_v),
        .tex_texel(tex_texel),
        .rgb      (rgb),
        .hit_idx  (hit_idx),
        .cov_count(cov_count),
        .cov_valid(cov_valid)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // One VGA pixel: EVAL cycle then SHADE cycle at the same x/y.
    task automatic drive_px(input int xv, input int yv);
        x = 10'(xv);
        y = 10'(yv);
        step_cycle();
        step_cycle();
    endtask

    // End-of-previous-line reload, so line yv starts from the init values.
    task automatic line_reload(input int yv);
        x = 10'd799;
        y = (yv == 0) ? 10'd524 : 10'(yv - 1);
        step_cycle();
    endtask

    task automatic set_tri(input int t, input int e0, input int e1, input int e2,
                           input int d0, input int d1, input int d2);
        e_init[(3*t+0)*EW +: EW] = EW'(e0);
        e_init[(3*t+1)*EW +: EW] = EW'(e1);
        e_init[(3*t+2)*EW +: EW] = EW'(e2);
        e_dx[(3*t+0)*EW +: EW]   = EW'(d0);
        e_dx[(3*t+1)*EW +: EW]   = EW'(d1);
        e_dx[(3*t+2)*EW +: EW]   = EW'(d2);
    endtask

    task automatic set_bary(input int t, input int byi, input int byd,
                            input int bzi, input int bzd);
        by_init[t*BW +: BW] = BW'(byi);
        by_dx[t*BW +: BW]   = BW'(byd);
        bz_init[t*BW +: BW] = BW'(bzi);
        bz_dx[t*BW +: BW]   = BW'(bzd);
    endtask

    initial begin
        reset     = 1'b1;
        x         = 10'd799;
        y         = 10'd524;
        mode      = 3'd2;
        tri_en    = '0;
        e_init    = '0;
        e_dx      = '0;
        by_init   = '0;
        by_dx     = '0;
        bz_init   = '0;
        bz_dx     = '0;
        tri_color = '0;
        bg_color  = 6'h05;
        tex_tie   = 1'b0;
        tex_fix   = 1'b0;

        // Reset state
        #2 reset = 1'b0;
        repeat (3) step_cycle();
        check("reset rgb", int'(rgb), 0);
        check("reset tex_u", int'(tex_u), 0);
        check("reset tex_v", int'(tex_v), 0);
        check("reset hit_idx", int'(hit_idx), 0);
        check("reset cov_count", int'(cov_count), 0);
        check("reset cov_valid", int'(cov_valid), 0);
        reset = 1'b1;
        step_cycle();

        // First snapshot after reset: empty count, single pulse
        x = 10'd0;
        y = 10'd480;
        step_cycle();
        check("snap0 valid", int'(cov_valid), 1);
        check("snap0 count", int'(cov_count), 0);
        step_cycle();
        check("snap0 pulse end", int'(cov_valid), 0);

        // Full-coverage triangle over three complete lines, flat shading
        set_tri(0, -5, -5, -5, 0, 0, 0);
        tri_color[5:0] = 6'h13;
        tri_en = 2'b01;
        mode   = 3'd2;
        for (int ln = 0; ln < 3; ln++) begin
            line_reload(ln);
            for (int px = 0; px < 640; px++) begin
                drive_px(px, ln);
                if (px == 0 || px == 639) begin
                    check($sformatf("flat l%0d p%0d rgb", ln, px), int'(rgb), 'h13);
                end
            end
        end
        x = 10'd0;
        y = 10'd480;
        step_cycle();
        check("cov pulse", int'(cov_valid), 1);
        check("cov count", int'(cov_count), 1920);
        step_cycle();
        check("cov pulse end", int'(cov_valid), 0);
        check("cov count held", int'(cov_count), 1920);

        // Priority: both front, lowest enabled index wins
        set_tri(1, -5, -5, -5, 0, 0, 0);
        tri_color[11:6] = 6'h2A;
        tri_en = 2'b11;
        line_reload(10);
        drive_px(0, 10);
        check("prio both hit_idx", int'(hit_idx), 0);
        check("prio both rgb", int'(rgb), 'h13);
        tri_en = 2'b10;
        drive_px(1, 10);
        check("prio en1 hit_idx", int'(hit_idx), 1);
        check("prio en1 rgb", int'(rgb), 'h2A);

        // Facing debug and back-face culling
        set_tri(0, 3, 3, 3, 0, 0, 0);
        set_tri(1, -1, 1, -1, 0, 0, 0);
        tri_en = 2'b11;
        line_reload(11);
        mode = 3'b001;
        drive_px(0, 11);
        check("back debug rgb", int'(rgb), 'h2A);
        check("back debug hit_idx", int'(hit_idx), 0);
        mode = 3'b101;
        drive_px(1, 11);
        check("cull miss rgb", int'(rgb), 'h05);
        set_tri(1, -5, -5, -5, 0, 0, 0);
        line_reload(12);
        drive_px(0, 12);
        check("cull next rgb", int'(rgb), 'h3F);
        check("cull next hit_idx", int'(hit_idx), 1);
        mode = 3'b011;
        drive_px(1, 12);
        check("black rgb", int'(rgb), 'h00);
        mode = 3'b010;
        drive_px(2, 12);
        check("flat back rgb", int'(rgb), 'h13);
        check("flat back hit_idx", int'(hit_idx), 0);

        // Edge walk: -4 stepping +1 hits pixels 0..3, the zero at 4 misses,
        // and an idle gap outside the active area must not step anything
        set_tri(0, -4, -100, -100, 1, 0, 0);
        tri_en = 2'b01;
        mode   = 3'd2;
        exp_q  = '{6'h13, 6'h13, 6'h13, 6'h13, 6'h05, 6'h05, 6'h05};
        line_reload(20);
        for (int px = 0; px < 2; px++) begin
            drive_px(px, 20);
            exp_rgb = exp_q.pop_front();
            check($sformatf("walk p%0d rgb", px), int'(rgb), int'(exp_rgb));
        end
        x = 10'd700;
        step_cycle();
        check("blank rgb", int'(rgb), 0);
        repeat (3) step_cycle();
        check("blank rgb held", int'(rgb), 0);
        for (int px = 2; px < 7; px++) begin
            drive_px(px, 20);
            exp_rgb = exp_q.pop_front();
            check($sformatf("walk p%0d rgb", px), int'(rgb), int'(exp_rgb));
        end

        // Texture: u = n+1, v = 3(n+1); texel is the low bit of u
        set_tri(0, -5, -5, -5, 0, 0, 0);
        set_bary(0, 0, 'h4000, 0, 'h2000);
        mode    = 3'd0;
        tex_tie = 1'b1;
        line_reload(30);
        for (int px = 0; px < 6; px++) begin
            drive_px(px, 30);
            check($sformatf("tex p%0d u", px), int'(tex_u), px + 1);
            check($sformatf("tex p%0d v", px), int'(tex_v), 3 * (px + 1));
            check($sformatf("tex p%0d rgb", px), int'(rgb), ((px + 1) % 2 == 1) ? 'h13 : 'h05);
        end
        tex_tie = 1'b0;
        set_bary(0, 0, 0, 0, 0);

        // Mid-line reset: outputs clear at once, zeroed edges miss until the
        // next reload, and the next snapshot holds only post-reset coverage
        set_bary(1, 0, 0, 0, 'h2000);
        tri_en = 2'b10;
        mode   = 3'd2;
        line_reload(100);
        for (int px = 0; px < 300; px++) begin
            drive_px(px, 100);
        end
        check("pre-reset rgb", int'(rgb), 'h2A);
        check("pre-reset hit_idx", int'(hit_idx), 1);
        check("pre-reset tex_u", int'(tex_u), 44);
        x = 10'd300;
        y = 10'd100;
        reset = 1'b0;
        #1;
        check("async rgb", int'(rgb), 0);
        check("async hit_idx", int'(hit_idx), 0);
        check("async tex_u", int'(tex_u), 0);
        check("async tex_v", int'(tex_v), 0);
        check("async cov_count", int'(cov_count), 0);
        repeat (3) step_cycle();
        reset = 1'b1;
        for (int px = 301; px < 304; px++) begin
            drive_px(px, 100);
            check($sformatf("post-reset p%0d rgb", px), int'(rgb), 'h05);
            check($sformatf("post-reset p%0d cov_valid", px), int'(cov_valid), 0);
        end
        line_reload(101);
        for (int px = 0; px < 4; px++) begin
            drive_px(px, 101);
            check($sformatf("reloaded p%0d rgb", px), int'(rgb), 'h2A);
        end
        check("no early pulse", int'(cov_valid), 0);
        x = 10'd0;
        y = 10'd480;
        step_cycle();
        check("post-reset pulse", int'(cov_valid), 1);
        check("post-reset count", int'(cov_count), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
